// File: rtl/pc_unit.sv
// Program-counter unit: registered fetch PC with exception/return/redirect/stall
// priority selection and a circular return-address stack for call/return.
module pc_unit #(
  parameter int unsigned    W         = 32,
  parameter int unsigned    STEP      = 4,
  parameter logic [W-1:0]   RESET_VEC = '0,
  parameter logic [W-1:0]   EXC_VEC   = W'('h80),
  parameter int unsigned    RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           redirect_valid,
  input  logic [W-1:0]                   redirect_target,
  input  logic                           call_valid,
  input  logic                           ret_valid,
  input  logic                           exc_valid,
  output logic [W-1:0]                   pc_out,
  output logic                           pc_valid,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_err,
  output logic                           dbg_state
);

  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  localparam logic [W-1:0]  STEP_V     = W'(STEP);
  localparam logic [W-1:0]  ALIGN_MASK = ~(STEP_V - W'(1));
  localparam logic [CW-1:0] CNT_FULL   = CW'(RAS_DEPTH);
  localparam logic [PW-1:0] PTR_LAST   = PW'(RAS_DEPTH - 1);

  // Handshake: pc_out is a fetch address whenever pc_valid is high. There is no
  // back-pressure from fetch; stall is the only way to hold the PC.
  typedef enum logic {
    ST_WAKE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [W-1:0]    r_pc;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_top;
  logic            r_err;
  logic [W-1:0]    r_ras [RAS_DEPTH];

  logic [W-1:0]    w_pc_next;
  logic [CW-1:0]   w_count_next;
  logic [PW-1:0]   w_top_next;
  logic            w_err_next;
  logic            w_push_en;
  logic [PW-1:0]   w_push_idx;
  logic [W-1:0]    w_push_val;
  logic [W-1:0]    w_seq_pc;
  logic [W-1:0]    w_target;
  logic [W-1:0]    w_ras_top;
  logic            w_call;
  logic            w_ras_empty;
  logic            w_ras_full;
  logic [PW-1:0]   w_top_inc;
  logic [PW-1:0]   w_top_dec;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PTR_LAST : p - PW'(1);
  endfunction

  assign w_seq_pc    = r_pc + STEP_V;
  assign w_target    = redirect_target & ALIGN_MASK;
  assign w_ras_top   = r_ras[r_top] & ALIGN_MASK;
  assign w_call      = call_valid & redirect_valid;
  assign w_ras_empty = (r_count == '0);
  assign w_ras_full  = (r_count == CNT_FULL);
  assign w_top_inc   = ptr_inc(r_top);
  assign w_top_dec   = ptr_dec(r_top);
  assign w_push_val  = w_seq_pc;

  // State register: the first edge after reset release only raises pc_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_WAKE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_count_next = r_count;
    w_top_next   = r_top;
    w_err_next   = 1'b0;
    w_push_en    = 1'b0;
    w_push_idx   = w_top_inc;

    case (r_state)
      ST_WAKE: begin
        w_state_next = ST_RUN;
      end

      ST_RUN: begin
        if (exc_valid) begin
          w_pc_next    = EXC_VEC;
          w_count_next = '0;
        end else if (ret_valid) begin
          if (!w_ras_empty) begin
            w_pc_next = w_ras_top;
            if (w_call) begin
              // Call+return swaps the top entry in place; depth is unchanged.
              w_push_en  = 1'b1;
              w_push_idx = r_top;
            end else begin
              w_top_next   = w_top_dec;
              w_count_next = r_count - CW'(1);
            end
          end else begin
            w_pc_next  = redirect_valid ? w_target : r_pc;
            w_err_next = 1'b1;
            if (w_call) begin
              w_push_en    = 1'b1;
              w_push_idx   = w_top_inc;
              w_top_next   = w_top_inc;
              w_count_next = CW'(1);
            end
          end
        end else if (redirect_valid) begin
          w_pc_next = w_target;
          if (w_call) begin
            // A push into a full stack lands on the oldest slot (circular).
            w_push_en  = 1'b1;
            w_push_idx = w_top_inc;
            w_top_next = w_top_inc;
            if (w_ras_full) begin
              w_err_next = 1'b1;
            end else begin
              w_count_next = r_count + CW'(1);
            end
          end
        end else if (stall) begin
          w_pc_next = r_pc;
        end else begin
          w_pc_next = w_seq_pc;
        end
      end

      default: begin
        w_state_next = ST_WAKE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_VEC;
      r_count <= '0;
      r_top   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_count <= w_count_next;
      r_top   <= w_top_next;
      r_err   <= w_err_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        r_ras[i] <= '0;
      end
    end else if (w_push_en) begin
      r_ras[w_push_idx] <= w_push_val;
    end
  end

  assign pc_out    = r_pc;
  assign pc_valid  = (r_state == ST_RUN);
  assign ras_count = r_count;
  assign ras_err   = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: driver pushes hand-computed expectations into a
// queue; monitors pop and compare one entry per clock edge.
module tb_pc_unit;

  localparam int W  = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [W-1:0]  redirect_target = '0;
  logic          call_valid = 1'b0;
  logic          ret_valid = 1'b0;
  logic          exc_valid = 1'b0;
  logic [W-1:0]  pc_out;
  logic          pc_valid;
  logic [CW-1:0] ras_count;
  logic          ras_err;
  logic          dbg_state;

  logic          rv8 = 1'b0;
  logic [7:0]    rt8 = '0;
  logic [7:0]    pc8;
  logic          valid8;
  logic [CW-1:0] cnt8;
  logic          err8;
  logic          dbg8;

  int n_vec  = 0;
  int n_miss = 0;

  // {pc_valid, pc_out, ras_count, ras_err}
  logic [W+CW+1:0] exp_q[$];
  logic [7:0]      exp8_q[$];
  logic [W+CW+1:0] mon_e;
  logic [7:0]      mon8_e;

  pc_unit #(.W(32), .STEP(4), .RESET_VEC(32'h0), .EXC_VEC(32'h80), .RAS_DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .call_valid(call_valid), .ret_valid(ret_valid),
    .exc_valid(exc_valid), .pc_out(pc_out), .pc_valid(pc_valid), .ras_count(ras_count),
    .ras_err(ras_err), .dbg_state(dbg_state)
  );

  pc_unit #(.W(8), .STEP(4), .RESET_VEC(8'h0), .EXC_VEC(8'h80), .RAS_DEPTH(4)) u_dut8 (
    .clk(clk), .reset(reset), .stall(1'b0), .redirect_valid(rv8),
    .redirect_target(rt8), .call_valid(1'b0), .ret_valid(1'b0),
    .exc_valid(1'b0), .pc_out(pc8), .pc_valid(valid8), .ras_count(cnt8),
    .ras_err(err8), .dbg_state(dbg8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic rv, input logic [W-1:0] rt,
                       input logic cv, input logic rtv, input logic ev,
                       input logic [W-1:0] e_pc, input logic [CW-1:0] e_cnt,
                       input logic e_err);
    @(negedge clk);
    stall           = st;
    redirect_valid  = rv;
    redirect_target = rt;
    call_valid      = cv;
    ret_valid       = rtv;
    exc_valid       = ev;
    exp_q.push_back({1'b1, e_pc, e_cnt, e_err});
  endtask

  task automatic idle(input logic [W-1:0] e_pc, input logic [CW-1:0] e_cnt);
    drive(0, 0, '0, 0, 0, 0, e_pc, e_cnt, 0);
  endtask

  task automatic ret(input logic [W-1:0] e_pc, input logic [CW-1:0] e_cnt, input logic e_err);
    drive(0, 0, '0, 0, 1, 0, e_pc, e_cnt, e_err);
  endtask

  task automatic call(input logic [W-1:0] tgt, input logic [CW-1:0] e_cnt, input logic e_err);
    drive(0, 1, tgt, 1, 0, 0, tgt & ~32'h3, e_cnt, e_err);
  endtask

  task automatic drive8(input logic rv, input logic [7:0] rt, input logic [7:0] e_pc);
    @(negedge clk);
    rv8 = rv;
    rt8 = rt;
    exp8_q.push_back(e_pc);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("pc_valid",  64'(pc_valid),  64'(mon_e[W+CW+1]));
      chk("pc_out",    64'(pc_out),    64'(mon_e[W+CW:CW+1]));
      chk("ras_count", 64'(ras_count), 64'(mon_e[CW:1]));
      chk("ras_err",   64'(ras_err),   64'(mon_e[0]));
    end
  end

  always @(posedge clk) begin
    #1;
    if (exp8_q.size() > 0) begin
      mon8_e = exp8_q.pop_front();
      chk("pc8_out", 64'(pc8), 64'(mon8_e));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #2;
    chk("rst_pc",    64'(pc_out),    64'h0);
    chk("rst_valid", 64'(pc_valid),  64'h0);
    chk("rst_count", 64'(ras_count), 64'h0);
    chk("rst_err",   64'(ras_err),   64'h0);

    // Release: first edge raises pc_valid only, then sequential counting
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back({1'b1, 32'h0, 3'd0, 1'b0});
    idle(32'h4, 0);
    idle(32'h8, 0);
    idle(32'hC, 0);
    idle(32'h10, 0);

    // Redirect with alignment, stall with overriding redirect
    drive(0, 1, 32'h100, 0, 0, 0, 32'h100, 0, 0);
    drive(0, 1, 32'h203, 0, 0, 0, 32'h200, 0, 0);
    drive(1, 0, 32'h0,   0, 0, 0, 32'h200, 0, 0);
    drive(1, 1, 32'h40,  0, 0, 0, 32'h40,  0, 0);
    drive(1, 0, 32'h0,   0, 0, 0, 32'h40,  0, 0);

    // Call / return pair, then underflow
    drive(0, 1, 32'h10, 0, 0, 0, 32'h10, 0, 0);
    call(32'h80, 1, 0);
    idle(32'h84, 1);
    call(32'hC0, 2, 0);
    ret(32'h88, 1, 0);
    ret(32'h14, 0, 0);
    ret(32'h14, 0, 1);
    idle(32'h18, 0);

    // Overflow: 5 nested calls, oldest entry (0x1C) lost
    call(32'h100, 1, 0);
    call(32'h200, 2, 0);
    call(32'h300, 3, 0);
    call(32'h400, 4, 0);
    call(32'h500, 4, 1);
    ret(32'h404, 3, 0);
    ret(32'h304, 2, 0);
    ret(32'h204, 1, 0);
    ret(32'h104, 0, 0);
    ret(32'h104, 0, 1);

    // Call+ret together, with and without live entries; lone call_valid ignored
    call(32'h600, 1, 0);
    drive(0, 1, 32'h700, 1, 1, 0, 32'h108, 1, 0);
    ret(32'h604, 0, 0);
    drive(0, 1, 32'h800, 1, 1, 0, 32'h800, 1, 1);
    ret(32'h608, 0, 0);
    drive(0, 0, 32'h0, 1, 0, 0, 32'h60C, 0, 0);

    // Exception beats return and flushes the stack
    call(32'h900, 1, 0);
    call(32'hA00, 2, 0);
    drive(0, 0, 32'h0, 0, 1, 1, 32'h80, 0, 0);
    ret(32'h80, 0, 1);
    drive(1, 1, 32'h123, 1, 0, 1, 32'h80, 0, 0);
    idle(32'h84, 0);

    // Asynchronous reset with three live entries
    call(32'hB00, 1, 0);
    call(32'hC00, 2, 0);
    call(32'hD00, 3, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_pc",    64'(pc_out),    64'h0);
    chk("async_valid", 64'(pc_valid),  64'h0);
    chk("async_count", 64'(ras_count), 64'h0);
    chk("async_err",   64'(ras_err),   64'h0);
    @(negedge clk);
    reset           = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h300;
    exc_valid       = 1'b1;
    exp_q.push_back({1'b1, 32'h0, 3'd0, 1'b0});
    idle(32'h4, 0);
    ret(32'h4, 0, 1);
    idle(32'h8, 0);

    // 8-bit instance: sequential wrap past 0xFC
    drive8(1, 8'hF9, 8'hF8);
    drive8(0, 8'h00, 8'hFC);
    drive8(0, 8'h00, 8'h00);
    drive8(0, 8'h00, 8'h04);

    @(negedge clk);
    @(negedge clk);
    chk("drain_q",  64'(exp_q.size()),  64'h0);
    chk("drain_q8", 64'(exp8_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
